hub75_bcm_driver: RTL and testbench



---
 rtl/hub75_bcm_driver_if.sv | 20 ++
 rtl/hub75_bcm_driver.sv | 256 +++++++++++++++++++++++++
 tb/tb_hub75_bcm_driver.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hub75_bcm_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : hub75_bcm_driver_if
// Purpose  : Framebuffer read bus between the HUB75 driver and a synchronous
//            frame memory.
// Ports    : fb_addr  - read address, driven by the driver (master)
//            fb_rdata - read data, valid one clk after fb_addr (slave drives)
// Revision : 1.0 - initial release
// ============================================================================
interface hub75_bcm_driver_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 24
);
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_rdata;

  modport master (output fb_addr, input fb_rdata);
  modport slave  (input fb_addr, output fb_rdata);
endinterface
`default_nettype wire

// File: rtl/hub75_bcm_driver.sv
`default_nettype none
// ============================================================================
// Module   : hub75_bcm_driver
// Purpose  : HUB75 LED panel scanner using binary-coded modulation. Shifts one
//            bit plane of a line pair per pass, latches it, then lights it for
//            BASE_TIME<<plane pixel ticks.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            enable          - run scanning; sampled only in IDLE
//            fb (master)     - framebuffer read bus {line, col}
//            frame_done      - one-clk pulse after the last plane of a frame
//            H75_R1..H75_B2  - serial colour data
//            H75_A..H75_E    - line address
//            H75_Clk/Lat/OE  - shift clock, latch, output enable (active low)
//            swap_req/fb_sel - double-buffer swap (HUB75_BUF_SWAP_EN only)
// Config   : define HUB75_BUF_SWAP_EN to add double buffering; fb_addr then
//            gains an MSB equal to fb_sel.
// Notes    : ROWS must be at least 4 so that the line counter has >= 1 bit.
// Revision : 1.0 - initial release
// ============================================================================
module hub75_bcm_driver #(
  parameter int COLS      = 64,
  parameter int ROWS      = 32,
  parameter int BPC       = 4,
  parameter int CLK_DIV   = 27,
  parameter int BASE_TIME = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
`ifdef HUB75_BUF_SWAP_EN
  input  logic swap_req,
  output logic fb_sel,
`endif
  hub75_bcm_driver_if.master fb,
  output logic frame_done,
  output logic H75_R1, H75_G1, H75_B1, H75_R2, H75_G2, H75_B2,
  output logic H75_A, H75_B, H75_C, H75_D, H75_E,
  output logic H75_Clk, H75_Lat, H75_OE
);
  localparam int LINES   = ROWS / 2;
  localparam int LINE_W  = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int COL_W   = $clog2(COLS);
  localparam int PLANE_W = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int CNT_W   = $clog2(CLK_DIV);
  localparam int DISP_W  = $clog2((BASE_TIME << (BPC - 1)) + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHIFT    = 3'd1,
    S_LATCH_HI = 3'd2,
    S_LATCH_LO = 3'd3,
    S_DISPLAY  = 3'd4,
    S_NEXT     = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          tick_cnt_q, tick_cnt_d;
  logic [LINE_W-1:0]         line_q, line_d;
  logic [PLANE_W-1:0]        plane_q, plane_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic                      phase_q, phase_d;
  logic [DISP_W-1:0]         disp_cnt_q, disp_cnt_d;
  logic [LINE_W+COL_W-1:0]   addr_q, addr_d;
  logic [5:0]                rgb_q, rgb_d;
  logic [4:0]                line_out_q, line_out_d;
  logic                      hclk_q, hclk_d;
  logic                      lat_q, lat_d;
  logic                      oe_q, oe_d;
  logic                      frame_done_q, frame_done_d;

  logic                      tick;
  logic [BPC-1:0]            plane_mask;
  logic [5:0]                plane_bits;
  logic [DISP_W-1:0]         disp_load;

  assign tick       = (tick_cnt_q == CNT_W'(CLK_DIV - 1));
  assign plane_mask = BPC'(1) << plane_q;
  assign disp_load  = DISP_W'(BASE_TIME) << plane_q;

  // Channel k of fb_rdata occupies bits [k*BPC +: BPC]; pick the current plane.
  for (genvar k = 0; k < 6; k++) begin : g_plane_bit
    assign plane_bits[k] = |(fb.fb_rdata[k*BPC +: BPC] & plane_mask);
  end

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    plane_d      = plane_q;
    col_d        = col_q;
    phase_d      = phase_q;
    disp_cnt_d   = disp_cnt_q;
    addr_d       = addr_q;
    rgb_d        = rgb_q;
    line_out_d   = line_out_q;
    hclk_d       = hclk_q;
    lat_d        = lat_q;
    oe_d         = oe_q;
    frame_done_d = 1'b0;
    tick_cnt_d   = tick ? '0 : tick_cnt_q + CNT_W'(1);

    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          oe_d = 1'b1;
          if (enable) begin
            state_d = S_SHIFT;
            line_d  = '0;
            plane_d = '0;
            col_d   = '0;
            phase_d = 1'b0;
            addr_d  = '0;
          end
        end
        S_SHIFT: begin
          if (!phase_q) begin
            hclk_d  = 1'b0;
            rgb_d   = plane_bits;
            phase_d = 1'b1;
          end else begin
            hclk_d  = 1'b1;
            phase_d = 1'b0;
            if (col_q == COL_W'(COLS - 1)) begin
              col_d   = '0;
              state_d = S_LATCH_HI;
            end else begin
              // Next column's address goes out a full tick before its even
              // tick, leaving the memory its one-clk read latency.
              col_d  = col_q + COL_W'(1);
              addr_d = {line_q, col_q + COL_W'(1)};
            end
          end
        end
        S_LATCH_HI: begin
          hclk_d     = 1'b0;
          lat_d      = 1'b1;
          line_out_d = 5'(line_q);
          state_d    = S_LATCH_LO;
        end
        S_LATCH_LO: begin
          lat_d      = 1'b0;
          disp_cnt_d = disp_load;
          state_d    = S_DISPLAY;
        end
        S_DISPLAY: begin
          if (disp_cnt_q != '0) begin
            oe_d       = 1'b0;
            disp_cnt_d = disp_cnt_q - DISP_W'(1);
          end else begin
            oe_d    = 1'b1;
            state_d = S_NEXT;
          end
        end
        S_NEXT: begin
          col_d   = '0;
          phase_d = 1'b0;
          state_d = S_SHIFT;
          if (plane_q == PLANE_W'(BPC - 1)) begin
            plane_d = '0;
            if (line_q == LINE_W'(LINES - 1)) begin
              line_d       = '0;
              frame_done_d = 1'b1;
              state_d      = S_IDLE;
            end else begin
              line_d = line_q + LINE_W'(1);
            end
          end else begin
            plane_d = plane_q + PLANE_W'(1);
          end
          addr_d = {line_d, COL_W'(0)};
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      line_q       <= '0;
      plane_q      <= '0;
      col_q        <= '0;
      phase_q      <= 1'b0;
      disp_cnt_q   <= '0;
      addr_q       <= '0;
      rgb_q        <= '0;
      line_out_q   <= '0;
      hclk_q       <= 1'b0;
      lat_q        <= 1'b0;
      oe_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      line_q       <= line_d;
      plane_q      <= plane_d;
      col_q        <= col_d;
      phase_q      <= phase_d;
      disp_cnt_q   <= disp_cnt_d;
      addr_q       <= addr_d;
      rgb_q        <= rgb_d;
      line_out_q   <= line_out_d;
      hclk_q       <= hclk_d;
      lat_q        <= lat_d;
      oe_q         <= oe_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef HUB75_BUF_SWAP_EN
  logic swap_pend_q, swap_pend_d;
  logic fb_sel_q, fb_sel_d;

  // A request arriving in the frame_done cycle itself is honoured immediately.
  always_comb begin
    swap_pend_d = swap_pend_q | swap_req;
    fb_sel_d    = fb_sel_q;
    if (frame_done_d) begin
      fb_sel_d    = fb_sel_q ^ swap_pend_d;
      swap_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      swap_pend_q <= 1'b0;
      fb_sel_q    <= 1'b0;
    end else begin
      swap_pend_q <= swap_pend_d;
      fb_sel_q    <= fb_sel_d;
    end
  end

  assign fb_sel     = fb_sel_q;
  assign fb.fb_addr = {fb_sel_q, addr_q};
`else
  assign fb.fb_addr = addr_q;
`endif

  assign frame_done = frame_done_q;
  assign H75_R1     = rgb_q[0];
  assign H75_G1     = rgb_q[1];
  assign H75_B1     = rgb_q[2];
  assign H75_R2     = rgb_q[3];
  assign H75_G2     = rgb_q[4];
  assign H75_B2     = rgb_q[5];
  assign H75_A      = line_out_q[0];
  assign H75_B      = line_out_q[1];
  assign H75_C      = line_out_q[2];
  assign H75_D      = line_out_q[3];
  assign H75_E      = line_out_q[4];
  assign H75_Clk    = hclk_q;
  assign H75_Lat    = lat_q;
  assign H75_OE     = oe_q;
endmodule
`default_nettype wire

// File: tb/tb_hub75_bcm_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_hub75_bcm_driver
// Purpose  : Self-checking bench for hub75_bcm_driver with COLS=4, ROWS=4,
//            BPC=2, CLK_DIV=2, BASE_TIME=1. A negedge monitor condenses each
//            shift/latch/display pass into one record that is compared against
//            a table of hand-computed expectations.
// Config   : HUB75_BUF_SWAP_EN enables the double-buffer swap sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hub75_bcm_driver;
  localparam int COLS = 4, ROWS = 4, BPC = 2, CLK_DIV = 2, BASE_TIME = 1;
`ifdef HUB75_BUF_SWAP_EN
  localparam int AW = 4;
`else
  localparam int AW = 3;
`endif

  logic clk = 1'b0;
  logic rst, enable;
  logic frame_done;
  logic H75_R1, H75_G1, H75_B1, H75_R2, H75_G2, H75_B2;
  logic H75_A, H75_B, H75_C, H75_D, H75_E;
  logic H75_Clk, H75_Lat, H75_OE;
`ifdef HUB75_BUF_SWAP_EN
  logic swap_req, fb_sel;
`endif

  always #5 clk = ~clk;

  hub75_bcm_driver_if #(.ADDR_W(AW), .DATA_W(6*BPC)) fb_if ();

  hub75_bcm_driver #(
    .COLS(COLS), .ROWS(ROWS), .BPC(BPC), .CLK_DIV(CLK_DIV), .BASE_TIME(BASE_TIME)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
`ifdef HUB75_BUF_SWAP_EN
    .swap_req(swap_req), .fb_sel(fb_sel),
`endif
    .fb(fb_if), .frame_done(frame_done),
    .H75_R1(H75_R1), .H75_G1(H75_G1), .H75_B1(H75_B1),
    .H75_R2(H75_R2), .H75_G2(H75_G2), .H75_B2(H75_B2),
    .H75_A(H75_A), .H75_B(H75_B), .H75_C(H75_C), .H75_D(H75_D), .H75_E(H75_E),
    .H75_Clk(H75_Clk), .H75_Lat(H75_Lat), .H75_OE(H75_OE)
  );

  // Synchronous frame memory: one clk read latency.
  logic [11:0] mem [0:15];
  always @(posedge clk) fb_if.fb_rdata <= mem[int'(fb_if.fb_addr)];

  // One row per (line, plane) pass. r1_cols/g2_cols are the memory contents
  // for that line (column c in bits [2c+1:2c]); exp_r1/exp_g2 hold the bit
  // shifted at the c-th Clk rise in bit c.
  typedef struct {
    int         line;
    int         plane;
    logic [7:0] r1_cols;
    logic [7:0] g2_cols;
    logic [4:0] exp_a;
    int         exp_oe;
    logic [3:0] exp_r1;
    logic [3:0] exp_g2;
  } vec_t;
  vec_t vecs [0:3];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int         rec_count, fd_count, viol, fd_wide;
  int         cur_rises, cur_lats, oe_cyc;
  logic [3:0] cur_r1, cur_g2;
  logic [4:0] cur_a;
  logic       prev_hclk, prev_lat, prev_oe, prev_fd;
  logic [4:0] rec_a     [0:31];
  int         rec_rises [0:31];
  int         rec_lats  [0:31];
  int         rec_oe    [0:31];
  logic [3:0] rec_r1    [0:31];
  logic [3:0] rec_g2    [0:31];
  int         fd_at_rec [0:7];
  logic       sel_at_fd, sel_before_fd, msb_at_fd, prev_sel;

  always @(negedge clk) begin
    if (rst) begin
      rec_count = 0; fd_count = 0; cur_rises = 0; cur_lats = 0; oe_cyc = 0;
      cur_r1 = '0; cur_g2 = '0; cur_a = '0;
      prev_hclk = 1'b0; prev_lat = 1'b0; prev_oe = 1'b1; prev_fd = 1'b0;
      prev_sel = 1'b0; sel_at_fd = 1'b0; sel_before_fd = 1'b0; msb_at_fd = 1'b0;
    end else begin
      if (!H75_OE && (H75_Lat || (H75_Clk != prev_hclk))) viol++;
      if (H75_Clk && !prev_hclk) begin
        if (cur_rises < 4) begin
          cur_r1[cur_rises[1:0]] = H75_R1;
          cur_g2[cur_rises[1:0]] = H75_G2;
        end
        cur_rises++;
      end
      if (H75_Lat && !prev_lat) begin
        cur_lats++;
        cur_a = {H75_E, H75_D, H75_C, H75_B, H75_A};
      end
      if (!H75_OE) oe_cyc++;
      if (H75_OE && !prev_oe) begin
        if (rec_count < 32) begin
          rec_a[rec_count]     = cur_a;
          rec_rises[rec_count] = cur_rises;
          rec_lats[rec_count]  = cur_lats;
          rec_oe[rec_count]    = oe_cyc / CLK_DIV;
          rec_r1[rec_count]    = cur_r1;
          rec_g2[rec_count]    = cur_g2;
        end
        rec_count++;
        cur_rises = 0; cur_lats = 0; oe_cyc = 0; cur_r1 = '0; cur_g2 = '0;
      end
      if (frame_done) begin
        if (fd_count < 8) fd_at_rec[fd_count] = rec_count;
        fd_count++;
        msb_at_fd = fb_if.fb_addr[AW-1];
`ifdef HUB75_BUF_SWAP_EN
        sel_at_fd     = fb_sel;
        sel_before_fd = prev_sel;
`endif
      end
      if (frame_done && prev_fd) fd_wide++;
      prev_hclk = H75_Clk;
      prev_lat  = H75_Lat;
      prev_oe   = H75_OE;
      prev_fd   = frame_done;
`ifdef HUB75_BUF_SWAP_EN
      prev_sel  = fb_sel;
`endif
    end
  end

  task automatic wait_rec(input int n, input string name);
    int k = 0;
    while (rec_count < n && k < 2000) begin @(negedge clk); k++; end
    check(name, int'(rec_count >= n), 1);
  endtask

  task automatic wait_fd(input int n, input string name);
    int k = 0;
    while (fd_count < n && k < 2000) begin @(negedge clk); k++; end
    check(name, int'(fd_count >= n), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t v;
    logic [7:0] r1w, g2w;
    int k;

    viol = 0; fd_wide = 0;
    vecs[0] = '{line:0, plane:0, r1_cols:8'hAA, g2_cols:8'h55, exp_a:5'd0, exp_oe:1, exp_r1:4'b0000, exp_g2:4'b1111};
    vecs[1] = '{line:0, plane:1, r1_cols:8'hAA, g2_cols:8'h55, exp_a:5'd0, exp_oe:2, exp_r1:4'b1111, exp_g2:4'b0000};
    vecs[2] = '{line:1, plane:0, r1_cols:8'hE4, g2_cols:8'h1B, exp_a:5'd1, exp_oe:1, exp_r1:4'b1010, exp_g2:4'b0101};
    vecs[3] = '{line:1, plane:1, r1_cols:8'hE4, g2_cols:8'h1B, exp_a:5'd1, exp_oe:2, exp_r1:4'b1100, exp_g2:4'b0011};

    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      r1w = v.r1_cols;
      g2w = v.g2_cols;
      if (v.plane == 0)
        for (int c = 0; c < COLS; c++)
          for (int b = 0; b < 2; b++)
            mem[b*8 + v.line*4 + c] = {2'b00, g2w[2*c +: 2], 6'b000000, r1w[2*c +: 2]};
    end

    rst = 1'b1; enable = 1'b0;
`ifdef HUB75_BUF_SWAP_EN
    swap_req = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_oe",         int'(H75_OE), 1);
    check("rst_lat",        int'(H75_Lat), 0);
    check("rst_clk",        int'(H75_Clk), 0);
    check("rst_colours",    int'({H75_R1, H75_G1, H75_B1, H75_R2, H75_G2, H75_B2}), 0);
    check("rst_addr_lines", int'({H75_E, H75_D, H75_C, H75_B, H75_A}), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_fb_addr",    int'(fb_if.fb_addr), 0);
    rst = 1'b0;

    // Two full frames, checked pass by pass against the table.
    enable = 1'b1;
    wait_fd(2, "timeout_two_frames");
    check("fd0_after_rec", fd_at_rec[0], 4);
    check("fd1_after_rec", fd_at_rec[1], 8);
    for (int i = 0; i < 8; i++) begin
      v = vecs[i % 4];
      check($sformatf("rec%0d_line", i),    int'(rec_a[i]), int'(v.exp_a));
      check($sformatf("rec%0d_rises", i),   rec_rises[i], COLS);
      check($sformatf("rec%0d_latches", i), rec_lats[i], 1);
      check($sformatf("rec%0d_oe_ticks", i), rec_oe[i], v.exp_oe);
      check($sformatf("rec%0d_r1", i),      int'(rec_r1[i]), int'(v.exp_r1));
      check($sformatf("rec%0d_g2", i),      int'(rec_g2[i]), int'(v.exp_g2));
    end

    // Drop enable in the middle of frame 3: it must still complete.
    wait_rec(9, "timeout_rec9");
    enable = 1'b0;
    wait_fd(3, "timeout_frame3");
    check("frame3_complete", rec_count, 12);
    repeat (60) @(negedge clk);
    check("idle_no_rescan", rec_count, 12);
    check("idle_no_fd",     fd_count, 3);
    check("idle_oe",        int'(H75_OE), 1);

    // Reset while the panel is lit.
    enable = 1'b1;
    k = 0;
    while (H75_OE && k < 500) begin @(negedge clk); k++; end
    check("timeout_display", int'(H75_OE), 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_disp_oe",      int'(H75_OE), 1);
    check("rst_disp_lat",     int'(H75_Lat), 0);
    check("rst_disp_clk",     int'(H75_Clk), 0);
    check("rst_disp_fb_addr", int'(fb_if.fb_addr), 0);
    check("rst_disp_lines",   int'({H75_E, H75_D, H75_C, H75_B, H75_A}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

`ifdef HUB75_BUF_SWAP_EN
    check("swap_rst_sel", int'(fb_sel), 0);
    wait_rec(1, "timeout_swap_rec");
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    check("swap_pending_sel", int'(fb_sel), 0);
    wait_fd(1, "timeout_swap_fd");
    check("swap_sel_before_fd", int'(sel_before_fd), 0);
    check("swap_sel_at_fd",     int'(sel_at_fd), 1);
    check("swap_addr_msb",      int'(msb_at_fd), 1);
`endif

    check("oe_protocol_violations", viol, 0);
    check("frame_done_wide_pulses", fd_wide, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
